// File: rtl/mem_arbiter_if.sv
// rtl/mem_arbiter_if.sv - bus bundle between the fetch/load-store requesters, the arbiter and memory
//
// Purpose: groups every handshake and data signal of mem_arbiter.
// Signals:
//   i_read, i_addr, i_rdata, i_resp                     instruction-side port
//   d_read, d_write, d_addr, d_wdata, d_byte_enable,
//   d_rdata, d_resp                                     data-side port
//   pmem_read, pmem_write, pmem_addr, pmem_wdata,
//   pmem_byte_enable, pmem_rdata, pmem_resp             shared memory port
// Modports:
//   slave  - the arbiter's view
//   master - the environment's view (requesters + memory)
interface mem_arbiter_if #(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32,
   parameter int MASK_W = DATA_W / 8
);
   logic              i_read;
   logic [ADDR_W-1:0] i_addr;
   logic [DATA_W-1:0] i_rdata;
   logic              i_resp;

   logic              d_read;
   logic              d_write;
   logic [ADDR_W-1:0] d_addr;
   logic [DATA_W-1:0] d_wdata;
   logic [MASK_W-1:0] d_byte_enable;
   logic [DATA_W-1:0] d_rdata;
   logic              d_resp;

   logic              pmem_read;
   logic              pmem_write;
   logic [ADDR_W-1:0] pmem_addr;
   logic [DATA_W-1:0] pmem_wdata;
   logic [MASK_W-1:0] pmem_byte_enable;
   logic [DATA_W-1:0] pmem_rdata;
   logic              pmem_resp;

   modport slave (
      input  i_read, i_addr,
      output i_rdata, i_resp,
      input  d_read, d_write, d_addr, d_wdata, d_byte_enable,
      output d_rdata, d_resp,
      output pmem_read, pmem_write, pmem_addr, pmem_wdata, pmem_byte_enable,
      input  pmem_rdata, pmem_resp
   );

   modport master (
      output i_read, i_addr,
      input  i_rdata, i_resp,
      output d_read, d_write, d_addr, d_wdata, d_byte_enable,
      input  d_rdata, d_resp,
      input  pmem_read, pmem_write, pmem_addr, pmem_wdata, pmem_byte_enable,
      output pmem_rdata, pmem_resp
   );
endinterface

// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - round-robin arbiter of fetch and load/store onto one memory port
//
// Purpose: latches one request at a time from the instruction or data side,
// drives it on the memory port until pmem_resp, and routes the completion
// back to the owner with zero added latency. Ties alternate between sides.
// Ports:
//   clk  - rising-edge clock
//   rst  - synchronous active-low reset
//   bus  - mem_arbiter_if.slave (requester ports and memory port)
module mem_arbiter #(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32,
   parameter int MASK_W = DATA_W / 8
) (
   input logic          clk,
   input logic          rst,
   mem_arbiter_if.slave bus
);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_I    = 2'd1,
      S_D    = 2'd2
   } state_t;

   state_t            state, state_next;
   logic              last_d, last_d_next;
   logic              cmd_read, cmd_read_next;
   logic              cmd_write, cmd_write_next;
   logic [ADDR_W-1:0] cmd_addr, cmd_addr_next;
   logic [DATA_W-1:0] cmd_wdata, cmd_wdata_next;
   logic [MASK_W-1:0] cmd_be, cmd_be_next;

   logic i_req, d_req, grant_i, grant_d;

   always_ff @(posedge clk) begin
      if (!rst) begin
         state     <= S_IDLE;
         last_d    <= 1'b1;   // instruction side wins the first tie
         cmd_read  <= 1'b0;
         cmd_write <= 1'b0;
         cmd_addr  <= '0;
         cmd_wdata <= '0;
         cmd_be    <= '0;
      end else begin
         state     <= state_next;
         last_d    <= last_d_next;
         cmd_read  <= cmd_read_next;
         cmd_write <= cmd_write_next;
         cmd_addr  <= cmd_addr_next;
         cmd_wdata <= cmd_wdata_next;
         cmd_be    <= cmd_be_next;
      end
   end

   always_comb begin
      state_next     = state;
      last_d_next    = last_d;
      cmd_read_next  = cmd_read;
      cmd_write_next = cmd_write;
      cmd_addr_next  = cmd_addr;
      cmd_wdata_next = cmd_wdata;
      cmd_be_next    = cmd_be;
      bus.i_resp     = 1'b0;
      bus.i_rdata    = '0;
      bus.d_resp     = 1'b0;
      bus.d_rdata    = '0;

      i_req   = bus.i_read;
      d_req   = bus.d_read | bus.d_write;
      // On a tie the side that did not get the previous grant goes next.
      grant_i = i_req & (~d_req | last_d);
      grant_d = d_req & (~i_req | ~last_d);

      case (state)
         S_IDLE: begin
            if (grant_i) begin
               state_next     = S_I;
               last_d_next    = 1'b0;
               cmd_read_next  = 1'b1;
               cmd_write_next = 1'b0;
               cmd_addr_next  = bus.i_addr;
               cmd_be_next    = '0;
            end else if (grant_d) begin
               state_next     = S_D;
               last_d_next    = 1'b1;
               // read+write together is treated as a write
               cmd_read_next  = bus.d_read & ~bus.d_write;
               cmd_write_next = bus.d_write;
               cmd_addr_next  = bus.d_addr;
               cmd_wdata_next = bus.d_wdata;
               cmd_be_next    = bus.d_byte_enable;
            end
         end
         S_I: begin
            if (bus.pmem_resp) begin
               bus.i_resp     = 1'b1;
               bus.i_rdata    = bus.pmem_rdata;
               state_next     = S_IDLE;
               cmd_read_next  = 1'b0;
               cmd_write_next = 1'b0;
            end
         end
         S_D: begin
            if (bus.pmem_resp) begin
               bus.d_resp     = 1'b1;
               bus.d_rdata    = bus.pmem_rdata;
               state_next     = S_IDLE;
               cmd_read_next  = 1'b0;
               cmd_write_next = 1'b0;
            end
         end
         default: begin
            state_next     = S_IDLE;
            cmd_read_next  = 1'b0;
            cmd_write_next = 1'b0;
         end
      endcase
   end

   assign bus.pmem_read        = cmd_read;
   assign bus.pmem_write       = cmd_write;
   assign bus.pmem_addr        = cmd_addr;
   assign bus.pmem_wdata       = cmd_wdata;
   assign bus.pmem_byte_enable = cmd_be;

endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - directed self-checking bench for mem_arbiter
module tb_mem_arbiter;

   logic clk = 1'b0;
   logic rst = 1'b0;
   int   checks   = 0;
   int   failures = 0;

   always #5 clk = ~clk;

   mem_arbiter_if bus ();

   mem_arbiter dut (
      .clk (clk),
      .rst (rst),
      .bus (bus.slave)
   );

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      if (obs !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   // advance to just after the next rising edge; inputs are driven here
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Entered just after the edge that makes the command visible. Checks the
   // command, holds it for lat cycles, answers with pmem_resp and checks the
   // completion. Returns just after the edge following the resp cycle.
   task automatic serve(input string tag, input bit exp_d, input logic [31:0] exp_addr,
                        input bit exp_wr, input logic [31:0] exp_wdata, input logic [3:0] exp_be,
                        input logic [31:0] rdata, input int lat);
      @(negedge clk);
      check({tag, ".read"},  bus.pmem_read, !exp_wr);
      check({tag, ".write"}, bus.pmem_write, exp_wr);
      check({tag, ".addr"},  bus.pmem_addr, exp_addr);
      check({tag, ".be"},    bus.pmem_byte_enable, exp_be);
      if (exp_wr) check({tag, ".wdata"}, bus.pmem_wdata, exp_wdata);
      for (int n = 1; n < lat; n++) begin
         tick();
         @(negedge clk);
         check({tag, ".hold_addr"}, bus.pmem_addr, exp_addr);
      end
      tick();
      bus.pmem_resp  = 1'b1;
      bus.pmem_rdata = rdata;
      @(negedge clk);
      check({tag, ".i_resp"}, bus.i_resp, !exp_d);
      check({tag, ".d_resp"}, bus.d_resp, exp_d);
      check({tag, ".i_rdata"}, bus.i_rdata, exp_d ? 32'h0 : rdata);
      check({tag, ".d_rdata"}, bus.d_rdata, exp_d ? rdata : 32'h0);
      check({tag, ".cmd_in_resp"}, bus.pmem_read | bus.pmem_write, 1'b1);
      tick();
      bus.pmem_resp  = 1'b0;
      bus.pmem_rdata = '0;
   endtask

   task automatic do_reset();
      rst = 1'b0;
      tick();
      rst = 1'b1;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      bus.i_read = 0; bus.i_addr = '0;
      bus.d_read = 0; bus.d_write = 0; bus.d_addr = '0; bus.d_wdata = '0; bus.d_byte_enable = '0;
      bus.pmem_rdata = '0; bus.pmem_resp = 0;

      // reset state
      tick(); tick();
      @(negedge clk);
      check("rst.read",  bus.pmem_read, 1'b0);
      check("rst.write", bus.pmem_write, 1'b0);
      check("rst.addr",  bus.pmem_addr, 32'h0);
      check("rst.wdata", bus.pmem_wdata, 32'h0);
      check("rst.be",    bus.pmem_byte_enable, 4'h0);
      check("rst.i_resp", bus.i_resp, 1'b0);
      check("rst.d_resp", bus.d_resp, 1'b0);
      tick();
      rst = 1'b1;
      tick();

      // single fetch, memory answers 3 cycles after the command
      bus.i_read = 1; bus.i_addr = 32'h60;
      @(negedge clk);
      check("fetch.no_early_cmd", bus.pmem_read, 1'b0);
      tick();
      serve("fetch", 1'b0, 32'h60, 1'b0, 32'h0, 4'h0, 32'h0000_0013, 3);
      bus.i_read = 0;
      @(negedge clk);
      check("fetch.cleared", bus.pmem_read, 1'b0);
      check("fetch.i_resp_low", bus.i_resp, 1'b0);
      tick();

      // simultaneous requests right after reset: instruction first
      do_reset();
      bus.i_read = 1; bus.i_addr = 32'h100;
      bus.d_write = 1; bus.d_addr = 32'h200; bus.d_wdata = 32'hDEAD_BEEF; bus.d_byte_enable = 4'hF;
      tick();
      serve("sim_i", 1'b0, 32'h100, 1'b0, 32'h0, 4'h0, 32'h1111_1111, 1);
      bus.i_read = 0;
      @(negedge clk);
      check("sim.idle_gap", bus.pmem_read | bus.pmem_write, 1'b0);
      tick();
      serve("sim_d", 1'b1, 32'h200, 1'b1, 32'hDEAD_BEEF, 4'hF, 32'h5555_AAAA, 2);
      bus.d_write = 0;
      tick();

      // round robin under continuous load: I,D,I,D,I,D with one idle cycle between
      do_reset();
      bus.i_read = 1; bus.i_addr = 32'h1000;
      bus.d_read = 1; bus.d_addr = 32'h2000; bus.d_byte_enable = 4'h3;
      tick();
      for (int k = 0; k < 6; k++) begin
         if (k % 2 == 0)
            serve("rr_i", 1'b0, 32'h1000, 1'b0, 32'h0, 4'h0, 32'h100 + k, 1);
         else
            serve("rr_d", 1'b1, 32'h2000, 1'b0, 32'h0, 4'h3, 32'h200 + k, 1);
         @(negedge clk);
         check("rr.idle_gap", bus.pmem_read | bus.pmem_write, 1'b0);
         if (k == 5) begin
            bus.i_read = 0;
            bus.d_read = 0;
         end
         tick();
      end
      @(negedge clk);
      check("rr.drained", bus.pmem_read | bus.pmem_write, 1'b0);
      tick();

      // read+write together latches as a write
      bus.d_read = 1; bus.d_write = 1; bus.d_addr = 32'h500;
      bus.d_wdata = 32'h0BAD_F00D; bus.d_byte_enable = 4'h6;
      tick();
      serve("rw", 1'b1, 32'h500, 1'b1, 32'h0BAD_F00D, 4'h6, 32'h0, 1);
      bus.d_read = 0; bus.d_write = 0;
      tick();

      // requester address change during the transaction is ignored
      bus.d_read = 1; bus.d_addr = 32'h40; bus.d_byte_enable = 4'h0;
      tick();
      @(negedge clk);
      check("midchg.addr0", bus.pmem_addr, 32'h40);
      bus.d_addr = 32'h80;
      tick();
      @(negedge clk);
      check("midchg.addr1", bus.pmem_addr, 32'h40);
      check("midchg.read1", bus.pmem_read, 1'b1);
      tick();
      bus.pmem_resp = 1; bus.pmem_rdata = 32'hABCD;
      @(negedge clk);
      check("midchg.addr_resp", bus.pmem_addr, 32'h40);
      check("midchg.d_resp", bus.d_resp, 1'b1);
      check("midchg.d_rdata", bus.d_rdata, 32'hABCD);
      check("midchg.i_resp", bus.i_resp, 1'b0);
      tick();
      bus.pmem_resp = 0; bus.pmem_rdata = '0; bus.d_read = 0;
      tick();

      // reset in the middle of a data write aborts it
      bus.d_write = 1; bus.d_addr = 32'h300; bus.d_wdata = 32'h1234_5678; bus.d_byte_enable = 4'hC;
      tick();
      @(negedge clk);
      check("abort.write_on", bus.pmem_write, 1'b1);
      rst = 0; bus.d_write = 0;
      tick();
      rst = 1;
      bus.pmem_resp = 1; bus.pmem_rdata = 32'h77;
      @(negedge clk);
      check("abort.read",  bus.pmem_read, 1'b0);
      check("abort.write", bus.pmem_write, 1'b0);
      check("abort.addr",  bus.pmem_addr, 32'h0);
      check("abort.wdata", bus.pmem_wdata, 32'h0);
      check("abort.be",    bus.pmem_byte_enable, 4'h0);
      check("abort.late_i_resp", bus.i_resp, 1'b0);
      check("abort.late_d_resp", bus.d_resp, 1'b0);
      check("abort.late_d_rdata", bus.d_rdata, 32'h0);
      tick();
      bus.pmem_resp = 0; bus.pmem_rdata = '0;
      @(negedge clk);
      check("abort.still_idle", bus.pmem_read | bus.pmem_write, 1'b0);
      tick();

      // stray pmem_resp while idle, then a normal request still grants in one cycle
      bus.pmem_resp = 1; bus.pmem_rdata = 32'hFFFF_FFFF;
      @(negedge clk);
      check("stray.i_resp", bus.i_resp, 1'b0);
      check("stray.d_resp", bus.d_resp, 1'b0);
      check("stray.i_rdata", bus.i_rdata, 32'h0);
      tick();
      bus.pmem_resp = 0; bus.pmem_rdata = '0;
      @(negedge clk);
      check("stray.no_cmd", bus.pmem_read | bus.pmem_write, 1'b0);
      bus.i_read = 1; bus.i_addr = 32'h64;
      tick();
      serve("post_stray", 1'b0, 32'h64, 1'b0, 32'h0, 4'h0, 32'hC0DE, 1);
      bus.i_read = 0;
      tick();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Two-requester arbiter sharing the single physical memory port between the instruction-fetch side and the load/store side of the core. Each requester uses the same read/write/resp handshake that the core control FSM already drives (command held until `resp`). The arbiter latches one request at a time, forwards it to memory, and routes the response back to the owner. Simultaneous requests are resolved round-robin.

## Interface
Parameters:
- ADDR_W, 32, address width for all ports
- DATA_W, 32, data width for all ports
- MASK_W, DATA_W/8, byte-enable width

Ports:
- clk  in  1  clock; all state updates on the rising edge
- rst  in  1  synchronous, active-low reset; `rst==0` at a rising edge resets the block
- i_read  in  1  instruction-side read request
- i_addr  in  ADDR_W  instruction-side address
- i_rdata  out  DATA_W  read data returned to the instruction side
- i_resp  out  1  instruction-side completion pulse
- d_read  in  1  data-side read request
- d_write  in  1  data-side write request
- d_addr  in  ADDR_W  data-side address
- d_wdata  in  DATA_W  data-side write data
- d_byte_enable  in  MASK_W  data-side write byte mask
- d_rdata  out  DATA_W  read data returned to the data side
- d_resp  out  1  data-side completion pulse
- pmem_read  out  1  memory read command
- pmem_write  out  1  memory write command
- pmem_addr  out  ADDR_W  memory address
- pmem_wdata  out  DATA_W  memory write data
- pmem_byte_enable  out  MASK_W  memory byte mask
- pmem_rdata  in  DATA_W  memory read data
- pmem_resp  in  1  memory completion, high for exactly one cycle per command

## Operation
- States: S_IDLE, S_I (instruction transaction owns the port), S_D (data transaction owns the port).
- `last_d` register: 1 if the most recent grant went to the data side.
- S_IDLE with exactly one side requesting: grant that side.
  - Instruction side requests when `i_read` is high.
  - Data side requests when `d_read` or `d_write` is high.
- S_IDLE with both sides requesting: grant the instruction side if `last_d==1`; otherwise grant the data side.
- On grant, at the same edge:
  - Load the command registers: `pmem_addr` and the read/write bit; for the data side also `pmem_wdata` and `pmem_byte_enable`.
  - Set `last_d` to the granted side.
  - Move to S_I or S_D.
- A data request with `d_read` and `d_write` both high is latched as a write.
- An instruction grant always has `pmem_write=0` and `pmem_byte_enable=0`.
- In S_I/S_D, the latched command is held on `pmem_*` until `pmem_resp`. Requester input changes in this window are ignored.
- On `pmem_resp` in S_I:
  - `i_resp=1` and `i_rdata=pmem_rdata` in the same cycle, combinationally.
  - Next state is S_IDLE; `pmem_read`/`pmem_write` clear at that edge.
- On `pmem_resp` in S_D: same behaviour, using `d_resp`/`d_rdata`.
- `pmem_resp` in S_IDLE is ignored; neither resp output asserts.
- The non-owner side's resp output is always 0.
- `i_rdata`/`d_rdata` carry `pmem_rdata` whenever their resp output is high; they are 0 otherwise.
- Reset (`rst==0`): state S_IDLE, `last_d=1` (instruction side wins the first tie), all `pmem_*` outputs 0.
- Reset during S_I/S_D aborts the transaction; no resp is issued.

## Timing
- Grant latency: a request seen in S_IDLE in cycle t drives `pmem_read`/`pmem_write` from cycle t+1 (registered outputs).
- Completion: `pmem_resp` in cycle r gives requester resp in cycle r with zero added latency. `pmem_*` command bits are low in r+1.
- Back-to-back: the earliest next grant decision is in cycle r+1; its command appears in r+2. This gives one idle bus cycle between transactions.
- A requester must hold its command until its resp and deassert it by the cycle after resp. The core FSM does this by construction.
- Starvation bound: a continuously pending side waits at most one transaction of the other side.

## Test plan
- Single fetch: `i_read=1`, `i_addr=0x60`, memory responds 3 cycles after the command with `0x00000013` -> `pmem_read` rises in t+1 with `pmem_addr=0x60`; `i_resp=1` with `i_rdata=0x13` in the resp cycle; `d_resp=0` throughout.
- Simultaneous requests after reset: `i_read` with `i_addr=0x100` and `d_write` with `d_addr=0x200`, `d_wdata=0xDEADBEEF`, `be=0xF` in the same cycle ->
  - Instruction side is served first.
  - Then the data write issues with `pmem_addr=0x200`, `pmem_wdata=0xDEADBEEF`, `pmem_byte_enable=0xF`.
  - `d_resp` follows.
- Round-robin under continuous load: both sides hold requests across 6 transactions -> grants alternate I,D,I,D,I,D, with exactly one idle cycle between each transaction.
- Input change mid-transaction: after a data read grant to `0x40`, `d_addr` changes to `0x80` -> `pmem_addr` stays `0x40` until `pmem_resp`.
- Reset mid-transaction: `rst=0` in S_D before `pmem_resp` -> next cycle all `pmem_*` are 0 and state is S_IDLE; a late `pmem_resp` produces no `i_resp`/`d_resp`.
- Stray `pmem_resp` in S_IDLE -> no resp output and no state change.
